// File: rtl/lin_sched_pkg.sv
// lin_pkg: shared FSM state type and default sizing constants for lin_sched
package lin_pkg;
    localparam int LINES_MAX_DEF = 1080;
    localparam int CONFIRM_DEF   = 4;
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DECIDE} state_e;
endpackage

// File: rtl/lin_sched_if.sv
// lin_sched_if: sync/flag inputs and decision outputs of the line scheduler
interface lin_sched_if import lin_pkg::*; #(
    parameter int LINES_MAX = LINES_MAX_DEF
) ();
    localparam int LW = $clog2(LINES_MAX + 1);
    logic          en_i;
    logic          vs_i;
    logic          hs_i;
    logic          rx_i;
    logic          freeze_o;
    logic          invert_o;
    logic          frame_done_o;
    logic [LW-1:0] lines_o;
    modport master (output en_i, vs_i, hs_i, rx_i, input freeze_o, invert_o, frame_done_o, lines_o);
    modport slave  (input en_i, vs_i, hs_i, rx_i, output freeze_o, invert_o, frame_done_o, lines_o);
endinterface

// File: rtl/lin_sched_edge.sv
// lin_edge: registers a sync input and flags its rising edge, optionally one cycle later
module lin_edge #(
    parameter bit DELAY = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);
    logic cur_q, prev_q, rise_q;
    // sample input, keep previous sample, and hold a delayed copy of the edge
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cur_q  <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            cur_q  <= d_i;
            prev_q <= cur_q;
            rise_q <= cur_q & ~prev_q;
        end
    end
    assign rise_o = DELAY ? rise_q : (cur_q & ~prev_q);
endmodule

// File: rtl/lin_sched.sv
// lin_sched: per-frame dark-mode scheduler; LIN_SCHED_HYST_EN adds CONFIRM-frame hysteresis on invert_o
module lin_sched import lin_pkg::*; #(
    parameter int LINES_MAX = LINES_MAX_DEF,
    parameter int CONFIRM   = CONFIRM_DEF
) (
    input logic        clk_i,
    input logic        rst_ni,
    lin_sched_if.slave bus
);
    localparam int LW = $clog2(LINES_MAX + 1);
    state_e        state_q, state_d;
    logic [LW-1:0] line_q, line_d, bright_q, bright_d, lines_q, lines_d;
    logic          invert_q, invert_d, vs_rise, hs_d, frame_bright, empty;
`ifdef LIN_SCHED_HYST_EN
    localparam int CW = $clog2(CONFIRM + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif
    lin_edge #(.DELAY(1'b0)) u_vs (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.vs_i), .rise_o(vs_rise));
    lin_edge #(.DELAY(1'b1)) u_hs (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(bus.hs_i), .rise_o(hs_d));
    // tie counts as bright: compare 2*bright against lines one bit wider than the counters
    assign frame_bright = {bright_q, 1'b0} >= {1'b0, line_q};
    assign empty        = line_q == '0;
    // next-state, saturating line/bright counting and the per-frame decision
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        bright_d = bright_q;
        lines_d  = lines_q;
        invert_d = invert_q;
`ifdef LIN_SCHED_HYST_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE:    state_d = WAIT_VS;
            WAIT_VS: begin
                if (vs_rise) begin
                    state_d  = ACTIVE;
                    line_d   = '0;
                    bright_d = '0;
                end
            end
            ACTIVE: begin
                if (hs_d) begin
                    line_d   = line_q + LW'(line_q != LW'(LINES_MAX));
                    bright_d = bright_q + LW'(bus.rx_i && bright_q != LW'(LINES_MAX));
                end
                if (vs_rise) state_d = DECIDE;
            end
            default: begin
                state_d  = ACTIVE;
                line_d   = '0;
                bright_d = '0;
                lines_d  = line_q;
                if (!empty) begin
`ifdef LIN_SCHED_HYST_EN
                    if (frame_bright == invert_q) cnt_d = '0;
                    else if (cnt_q == CW'(CONFIRM - 1)) begin
                        cnt_d    = '0;
                        invert_d = ~invert_q;
                    end else cnt_d = cnt_q + 1'b1;
`else
                    invert_d = frame_bright;
`endif
                end
            end
        endcase
        if (!bus.en_i) begin
            state_d  = IDLE;
            line_d   = '0;
            bright_d = '0;
`ifdef LIN_SCHED_HYST_EN
            cnt_d    = '0;
`endif
        end
    end
    // state and counter registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            line_q   <= '0;
            bright_q <= '0;
            lines_q  <= '0;
            invert_q <= 1'b0;
`ifdef LIN_SCHED_HYST_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            bright_q <= bright_d;
            lines_q  <= lines_d;
            invert_q <= invert_d;
`ifdef LIN_SCHED_HYST_EN
            cnt_q    <= cnt_d;
`endif
        end
    end
    assign bus.freeze_o     = state_q == ACTIVE || state_q == DECIDE;
    assign bus.frame_done_o = state_q == DECIDE;
    assign bus.lines_o      = lines_q;
    assign bus.invert_o     = invert_q;
endmodule

// File: tb/tb_lin_sched.sv
// tb_lin_sched: scoreboard bench driving a full-size and an 8-line-max scheduler in parallel
module tb_lin_sched;
    typedef struct {int lines; int inv;} exp_t;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, vs = 1'b0, hs = 1'b0, rx = 1'b0;
    int   total = 0, passed = 0;
    int   inv_m [2] = '{0, 0};
    int   cnt_m [2] = '{0, 0};
    exp_t qa[$], qb[$];
    always #5 clk = ~clk;
    lin_sched_if #(.LINES_MAX(1080)) ifa ();
    lin_sched_if #(.LINES_MAX(8))    ifb ();
    assign ifa.en_i = en;
    assign ifa.vs_i = vs;
    assign ifa.hs_i = hs;
    assign ifa.rx_i = rx;
    assign ifb.en_i = en;
    assign ifb.vs_i = vs;
    assign ifb.hs_i = hs;
    assign ifb.rx_i = rx;
    lin_sched #(.LINES_MAX(1080), .CONFIRM(4)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));
    lin_sched #(.LINES_MAX(8),    .CONFIRM(4)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic line(input bit r);
        rx = r;
        hs = 1'b1;
        tick(1);
        hs = 1'b0;
        tick(3);
    endtask

    task automatic vsync();
        vs = 1'b1;
        tick(1);
        vs = 1'b0;
        tick(3);
    endtask

    // reference decision: saturated counts, 2*bright >= lines, optional hysteresis
    task automatic push(input int n, input int b);
        for (int d = 0; d < 2; d++) begin
            int mx, ns, bs, fb;
            exp_t e;
            mx = d ? 8 : 1080;
            ns = n < mx ? n : mx;
            bs = b < mx ? b : mx;
            fb = (2 * bs >= ns) ? 1 : 0;
            if (ns != 0) begin
`ifdef LIN_SCHED_HYST_EN
                if (fb == inv_m[d]) cnt_m[d] = 0;
                else if (cnt_m[d] == 3) begin
                    cnt_m[d] = 0;
                    inv_m[d] = 1 - inv_m[d];
                end else cnt_m[d]++;
`else
                inv_m[d] = fb;
`endif
            end
            e.lines = ns;
            e.inv = inv_m[d];
            if (d == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic frame(input int n, input int b);
        for (int i = 0; i < n; i++) line(i < b);
        push(n, b);
        vsync();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ifa.frame_done_o) begin
                exp_t e;
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                    e.lines = -1;
                    e.inv = -1;
                end else e = qa.pop_front();
                @(negedge clk);
                chk("a_lines", int'(ifa.lines_o), e.lines);
                chk("a_invert", int'(ifa.invert_o), e.inv);
                chk("a_done_pulse", int'(ifa.frame_done_o), 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ifb.frame_done_o) begin
                exp_t e;
                if (qb.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                    e.lines = -1;
                    e.inv = -1;
                end else e = qb.pop_front();
                @(negedge clk);
                chk("b_lines", int'(ifb.lines_o), e.lines);
                chk("b_invert", int'(ifb.invert_o), e.inv);
                chk("b_done_pulse", int'(ifb.frame_done_o), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        chk("rst_a_freeze", int'(ifa.freeze_o), 0);
        chk("rst_a_invert", int'(ifa.invert_o), 0);
        chk("rst_a_done", int'(ifa.frame_done_o), 0);
        chk("rst_a_lines", int'(ifa.lines_o), 0);
        chk("rst_b_freeze", int'(ifb.freeze_o), 0);
        chk("rst_b_invert", int'(ifb.invert_o), 0);
        chk("rst_b_done", int'(ifb.frame_done_o), 0);
        chk("rst_b_lines", int'(ifb.lines_o), 0);
        rst_n = 1'b1;
        en = 1'b1;
        tick(2);
        chk("wait_vs_freeze", int'(ifa.freeze_o), 0);
        vsync();
        chk("active_freeze", int'(ifa.freeze_o), 1);
        frame(10, 10);
        frame(10, 5);
        frame(10, 4);
        frame(0, 0);
        frame(12, 0);
        line(1'b1);
        line(1'b1);
        en = 1'b0;
        cnt_m = '{0, 0};
        tick(1);
        chk("en_a_freeze", int'(ifa.freeze_o), 0);
        chk("en_b_freeze", int'(ifb.freeze_o), 0);
        chk("en_a_invert", int'(ifa.invert_o), inv_m[0]);
        chk("en_b_lines", int'(ifb.lines_o), 8);
        en = 1'b1;
        tick(2);
        vsync();
        frame(3, 3);
        line(1'b1);
        line(1'b0);
        rst_n = 1'b0;
        inv_m = '{0, 0};
        cnt_m = '{0, 0};
        tick(1);
        chk("mid_rst_a_freeze", int'(ifa.freeze_o), 0);
        chk("mid_rst_a_invert", int'(ifa.invert_o), 0);
        chk("mid_rst_a_done", int'(ifa.frame_done_o), 0);
        chk("mid_rst_a_lines", int'(ifa.lines_o), 0);
        chk("mid_rst_b_freeze", int'(ifb.freeze_o), 0);
        chk("mid_rst_b_invert", int'(ifb.invert_o), 0);
        chk("mid_rst_b_done", int'(ifb.frame_done_o), 0);
        chk("mid_rst_b_lines", int'(ifb.lines_o), 0);
        rst_n = 1'b1;
        tick(2);
        vsync();
        frame(6, 3);
        tick(5);
        chk("a_missing_done", qa.size(), 0);
        chk("b_missing_done", qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
